// File: rtl/cpu_trap_unit_pkg.sv
// Shared types and constants for the trap unit: FSM states, privilege levels,
// decode exception codes, mcause values and mstatus bit positions.
package cpu_trap_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRAP_SAVE = 2'd1,
    ST_TRAP_JUMP = 2'd2,
    ST_MRET_JUMP = 2'd3
  } trap_state_t;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  localparam logic [1:0] EXCAUSE_ECALL         = 2'd0;
  localparam logic [1:0] EXCAUSE_BREAKPOINT    = 2'd1;
  localparam logic [1:0] EXCAUSE_ILLEGAL_INSTR = 2'd2;

  localparam logic [31:0] MCAUSE_ILLEGAL    = 32'd2;
  localparam logic [31:0] MCAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] MCAUSE_ECALL_U    = 32'd8;
  localparam logic [31:0] MCAUSE_ECALL_S    = 32'd9;
  localparam logic [31:0] MCAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] MCAUSE_IRQ_TIMER  = 32'h8000_0007;
  localparam logic [31:0] MCAUSE_IRQ_EXT    = 32'h8000_000B;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;

  // Reserved privilege 10 cannot occur; it falls back to the M-mode code.
  function automatic logic [31:0] ecall_cause(input logic [1:0] p);
    case (p)
      PRIV_U:  ecall_cause = MCAUSE_ECALL_U;
      PRIV_S:  ecall_cause = MCAUSE_ECALL_S;
      default: ecall_cause = MCAUSE_ECALL_M;
    endcase
  endfunction

endpackage

// File: rtl/cpu_trap_unit_if.sv
// Decode/CSR-side bus of the trap unit. Interrupt lines exist only when
// CPU_IRQ_EN is defined. valid/ready: a request is taken when instr_valid=1
// and the unit is idle; stall=1 in that cycle is the back-pressure answer.
interface cpu_trap_unit_if;
  logic        instr_valid;
  logic [31:0] pc;
  logic        exception;
  logic [1:0]  exception_cause;
  logic        illegal_instr;
  logic        mret;
  logic [1:0]  required_priv;
  logic [31:0] mtvec;
  logic [31:0] mepc;
`ifdef CPU_IRQ_EN
  logic        irq_timer;
  logic        irq_ext;
`endif
  logic        mstatus_we;
  logic [31:0] mstatus_wdata;
  logic        stall;
  logic        kill;
  logic        trap_csr_we;
  logic [31:0] trap_mepc;
  logic [31:0] trap_mcause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  priv;
  logic [31:0] mstatus;

  modport master (
`ifdef CPU_IRQ_EN
    output irq_timer, irq_ext,
`endif
    output instr_valid, pc, exception, exception_cause, illegal_instr, mret,
    output required_priv, mtvec, mepc, mstatus_we, mstatus_wdata,
    input  stall, kill, trap_csr_we, trap_mepc, trap_mcause,
    input  redirect_valid, redirect_pc, priv, mstatus
  );

  modport slave (
`ifdef CPU_IRQ_EN
    input  irq_timer, irq_ext,
`endif
    input  instr_valid, pc, exception, exception_cause, illegal_instr, mret,
    input  required_priv, mtvec, mepc, mstatus_we, mstatus_wdata,
    output stall, kill, trap_csr_we, trap_mepc, trap_mcause,
    output redirect_valid, redirect_pc, priv, mstatus
  );
endinterface

// File: rtl/cpu_trap_cause_enc.sv
// Priority select of the pending trap/mret request and its mcause value.
// Interrupt inputs exist only when CPU_IRQ_EN is defined.
module cpu_trap_cause_enc
  import cpu_trap_unit_pkg::*;
(
  input  logic [1:0]  priv,
`ifdef CPU_IRQ_EN
  input  logic        mie,
  input  logic        irq_timer,
  input  logic        irq_ext,
`endif
  input  logic        illegal_instr,
  input  logic [1:0]  required_priv,
  input  logic        mret,
  input  logic        exception,
  input  logic [1:0]  exception_cause,
  output logic        take_trap,
  output logic        take_mret,
  output logic [31:0] mcause
);

  logic illegal;
`ifdef CPU_IRQ_EN
  logic irq_enabled;
  assign irq_enabled = (priv != PRIV_M) || mie;
`endif

  // mret outside M mode is reported as an illegal instruction.
  assign illegal = illegal_instr || (required_priv > priv) ||
                   (mret && (priv != PRIV_M));

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    mcause    = '0;
`ifdef CPU_IRQ_EN
    if (irq_enabled && irq_ext) begin
      take_trap = 1'b1;
      mcause    = MCAUSE_IRQ_EXT;
    end else if (irq_enabled && irq_timer) begin
      take_trap = 1'b1;
      mcause    = MCAUSE_IRQ_TIMER;
    end else
`endif
    if (illegal) begin
      take_trap = 1'b1;
      mcause    = MCAUSE_ILLEGAL;
    end else if (exception) begin
      take_trap = 1'b1;
      case (exception_cause)
        EXCAUSE_ECALL:      mcause = ecall_cause(priv);
        EXCAUSE_BREAKPOINT: mcause = MCAUSE_BREAKPOINT;
        default:            mcause = MCAUSE_ILLEGAL;
      endcase
    end else if (mret) begin
      take_mret = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_trap_unit.sv
// Trap controller: accept -> save trap CSRs -> redirect, or accept -> mret
// redirect. Owns priv and MIE/MPIE/MPP. Interrupts enabled by CPU_IRQ_EN.
module cpu_trap_unit
  import cpu_trap_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_trap_unit_if.slave        bus,
  output trap_state_t           state_dbg
);

  trap_state_t state_q, state_d;
  logic [1:0]  priv_q, mpp_q;
  logic        mie_q, mpie_q;
  logic [31:0] epc_q, cause_q;
  logic        take_trap, take_mret;
  logic [31:0] enc_mcause;
  logic        accept_trap, accept_mret;
  logic [31:0] trap_target;
  logic [1:0]  wr_mpp;

  cpu_trap_cause_enc u_enc (
    .priv            (priv_q),
`ifdef CPU_IRQ_EN
    .mie             (mie_q),
    .irq_timer       (bus.irq_timer),
    .irq_ext         (bus.irq_ext),
`endif
    .illegal_instr   (bus.illegal_instr),
    .required_priv   (bus.required_priv),
    .mret            (bus.mret),
    .exception       (bus.exception),
    .exception_cause (bus.exception_cause),
    .take_trap       (take_trap),
    .take_mret       (take_mret),
    .mcause          (enc_mcause)
  );

  assign accept_trap = (state_q == ST_IDLE) && bus.instr_valid && take_trap;
  assign accept_mret = (state_q == ST_IDLE) && bus.instr_valid && take_mret;

  // Vectored mode: interrupts land at base + 4*code, 32-bit wraparound.
`ifdef CPU_IRQ_EN
  assign trap_target = (bus.mtvec & 32'hFFFF_FFFC) +
                       ((bus.mtvec[0] && cause_q[31]) ? {cause_q[29:0], 2'b00} : 32'd0);
`else
  assign trap_target = bus.mtvec & 32'hFFFF_FFFC;
`endif

  assign wr_mpp = (bus.mstatus_wdata[12:11] == 2'b10) ? PRIV_U : bus.mstatus_wdata[12:11];

  always_comb begin
    state_d            = state_q;
    bus.stall          = 1'b0;
    bus.kill           = 1'b0;
    bus.trap_csr_we    = 1'b0;
    bus.trap_mepc      = '0;
    bus.trap_mcause    = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = RESET_PC;
    case (state_q)
      ST_IDLE: begin
        if (accept_trap) begin
          bus.stall = 1'b1;
          bus.kill  = 1'b1;
          state_d   = ST_TRAP_SAVE;
        end else if (accept_mret) begin
          bus.stall = 1'b1;
          state_d   = ST_MRET_JUMP;
        end
      end
      ST_TRAP_SAVE: begin
        bus.stall       = 1'b1;
        bus.trap_csr_we = 1'b1;
        bus.trap_mepc   = epc_q;
        bus.trap_mcause = cause_q;
        state_d         = ST_TRAP_JUMP;
      end
      ST_TRAP_JUMP: begin
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = trap_target;
        state_d            = ST_IDLE;
      end
      ST_MRET_JUMP: begin
        bus.stall          = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.mepc & 32'hFFFF_FFFC;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      priv_q  <= PRIV_M;
      mie_q   <= 1'b0;
      mpie_q  <= 1'b0;
      mpp_q   <= PRIV_U;
      epc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_trap) begin
        epc_q   <= bus.pc;
        cause_q <= enc_mcause;
      end
      if (state_q == ST_TRAP_SAVE) begin
        mpie_q <= mie_q;
        mie_q  <= 1'b0;
        mpp_q  <= priv_q;
        priv_q <= PRIV_M;
      end else if (state_q == ST_MRET_JUMP) begin
        priv_q <= mpp_q;
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
        mpp_q  <= PRIV_U;
      end else if (state_q == ST_IDLE && !accept_trap && !accept_mret && bus.mstatus_we) begin
        mie_q  <= bus.mstatus_wdata[MSTATUS_MIE_BIT];
        mpie_q <= bus.mstatus_wdata[MSTATUS_MPIE_BIT];
        mpp_q  <= wr_mpp;
      end
    end
  end

  always_comb begin
    bus.mstatus = '0;
    bus.mstatus[MSTATUS_MIE_BIT]                    = mie_q;
    bus.mstatus[MSTATUS_MPIE_BIT]                   = mpie_q;
    bus.mstatus[MSTATUS_MPP_LO+1:MSTATUS_MPP_LO]    = mpp_q;
  end

  assign bus.priv  = priv_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cpu_trap_unit.sv
// Directed bench for cpu_trap_unit; the interrupt case runs when CPU_IRQ_EN
// is defined. Expected CSR writes and redirects go through exp_q.
module tb_cpu_trap_unit;
  import cpu_trap_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  trap_state_t state_dbg;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  cpu_trap_unit_if bus ();

  cpu_trap_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    bus.instr_valid     = 1'b0;
    bus.pc              = '0;
    bus.exception       = 1'b0;
    bus.exception_cause = EXCAUSE_ECALL;
    bus.illegal_instr   = 1'b0;
    bus.mret            = 1'b0;
    bus.required_priv   = PRIV_U;
    bus.mstatus_we      = 1'b0;
    bus.mstatus_wdata   = '0;
  endtask

  task automatic expect_trap(input logic [31:0] epc, input logic [31:0] cause,
                             input logic [31:0] target);
    exp_q.push_back(epc);
    exp_q.push_back(cause);
    exp_q.push_back(target);
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 32'hDEAD_BEEF;
    return exp_q.pop_front();
  endfunction

  // Drive one request for a cycle, check the combinational accept strobes.
  task automatic issue(input string tag, input logic [31:0] pc_v, input logic exc,
                       input logic [1:0] cause_v, input logic ill, input logic mret_v,
                       input logic [1:0] rp, input logic exp_kill);
    bus.instr_valid     = 1'b1;
    bus.pc              = pc_v;
    bus.exception       = exc;
    bus.exception_cause = cause_v;
    bus.illegal_instr   = ill;
    bus.mret            = mret_v;
    bus.required_priv   = rp;
    #1;
    check({tag, " accept stall"}, {31'd0, bus.stall}, 32'd1);
    check({tag, " accept kill"}, {31'd0, bus.kill}, {31'd0, exp_kill});
    tick();
    clear_req();
  endtask

  task automatic wait_csr(input string tag);
    int lat = 0;
    while (!bus.trap_csr_we && lat < 6) begin
      tick();
      lat++;
    end
    if (!bus.trap_csr_we) begin
      check({tag, " csr write timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " csr latency"}, lat, 32'd0);
      check({tag, " mepc"}, bus.trap_mepc, pop_exp());
      check({tag, " mcause"}, bus.trap_mcause, pop_exp());
    end
  endtask

  task automatic wait_redirect(input string tag);
    int lat = 0;
    while (!bus.redirect_valid && lat < 6) begin
      tick();
      lat++;
    end
    if (!bus.redirect_valid) begin
      check({tag, " redirect timeout"}, 32'd0, 32'd1);
    end else begin
      check({tag, " redirect latency"}, lat, 32'd0);
      check({tag, " redirect pc"}, bus.redirect_pc, pop_exp());
    end
  endtask

  task automatic write_mstatus(input string tag, input logic [31:0] wdata,
                               input logic [31:0] exp);
    bus.mstatus_we    = 1'b1;
    bus.mstatus_wdata = wdata;
    tick();
    bus.mstatus_we    = 1'b0;
    check({tag, " mstatus"}, bus.mstatus, exp);
  endtask

  initial begin
    clear_req();
    bus.mtvec = 32'h200;
    bus.mepc  = 32'h104;
`ifdef CPU_IRQ_EN
    bus.irq_timer = 1'b0;
    bus.irq_ext   = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    check("reset stall", {31'd0, bus.stall}, 32'd0);
    check("reset kill", {31'd0, bus.kill}, 32'd0);
    check("reset csr_we", {31'd0, bus.trap_csr_we}, 32'd0);
    check("reset redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("reset redirect_pc", bus.redirect_pc, 32'h0);
    check("reset trap_mepc", bus.trap_mepc, 32'h0);
    check("reset trap_mcause", bus.trap_mcause, 32'h0);
    check("reset priv", {30'd0, bus.priv}, {30'd0, PRIV_M});
    check("reset mstatus", bus.mstatus, 32'h0);

    // ecall in M mode
    expect_trap(32'h100, 32'd11, 32'h200);
    issue("ecall_m", 32'h100, 1'b1, EXCAUSE_ECALL, 1'b0, 1'b0, PRIV_U, 1'b1);
    wait_csr("ecall_m");
    tick();
    wait_redirect("ecall_m");
    check("ecall_m mstatus", bus.mstatus, 32'h1800);
    tick();
    check("ecall_m idle stall", {31'd0, bus.stall}, 32'd0);

    // MPP=10 is stored as 00; MIE=1, MPIE=0
    write_mstatus("wr_mpp10", 32'h0000_1008, 32'h0000_0008);

    // mret to U
    exp_q.push_back(32'h104);
    issue("mret_m", 32'h44, 1'b0, EXCAUSE_ECALL, 1'b0, 1'b1, PRIV_U, 1'b0);
    check("mret no csr write", {31'd0, bus.trap_csr_we}, 32'd0);
    wait_redirect("mret_m");
    tick();
    check("mret priv", {30'd0, bus.priv}, {30'd0, PRIV_U});
    check("mret mstatus", bus.mstatus, 32'h80);

    // U mode executing an M-only instruction; mtvec low bits are masked
    bus.mtvec = 32'h201;
    expect_trap(32'h40, 32'd2, 32'h200);
    issue("priv_viol", 32'h40, 1'b0, EXCAUSE_ECALL, 1'b0, 1'b0, PRIV_M, 1'b1);
    wait_csr("priv_viol");
    tick();
    wait_redirect("priv_viol");
    check("priv_viol priv", {30'd0, bus.priv}, {30'd0, PRIV_M});
    check("priv_viol mstatus", bus.mstatus, 32'h0);
    tick();

    // back to U, then mret in U is illegal; concurrent mstatus write is dropped
    exp_q.push_back(32'h104);
    issue("mret_to_u", 32'h48, 1'b0, EXCAUSE_ECALL, 1'b0, 1'b1, PRIV_U, 1'b0);
    wait_redirect("mret_to_u");
    tick();
    check("mret_to_u priv", {30'd0, bus.priv}, {30'd0, PRIV_U});
    expect_trap(32'h60, 32'd2, 32'h200);
    bus.mstatus_we    = 1'b1;
    bus.mstatus_wdata = 32'h88;
    issue("mret_u", 32'h60, 1'b0, EXCAUSE_ECALL, 1'b0, 1'b1, PRIV_U, 1'b1);
    wait_csr("mret_u");
    tick();
    wait_redirect("mret_u");
    check("mret_u mstatus", bus.mstatus, 32'h0);
    tick();

    // ebreak in M mode
    bus.mtvec = 32'h200;
    expect_trap(32'h80, 32'd3, 32'h200);
    issue("ebreak", 32'h80, 1'b1, EXCAUSE_BREAKPOINT, 1'b0, 1'b0, PRIV_U, 1'b1);
    wait_csr("ebreak");
    tick();
    wait_redirect("ebreak");
    tick();

    // reset during TRAP_SAVE aborts the sequence
    issue("rst_abort", 32'h90, 1'b1, EXCAUSE_ECALL, 1'b0, 1'b0, PRIV_U, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_abort stall", {31'd0, bus.stall}, 32'd0);
    check("rst_abort redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_abort csr_we", {31'd0, bus.trap_csr_we}, 32'd0);
    check("rst_abort priv", {30'd0, bus.priv}, {30'd0, PRIV_M});
    tick();
    check("rst_abort late redirect", {31'd0, bus.redirect_valid}, 32'd0);

`ifdef CPU_IRQ_EN
    write_mstatus("irq mie", 32'h8, 32'h8);
    bus.mtvec   = 32'h301;
    bus.irq_ext = 1'b1;
    #1;
    check("irq no instr_valid stall", {31'd0, bus.stall}, 32'd0);
    tick();
    expect_trap(32'h80, 32'h8000_000B, 32'h32C);
    issue("irq_ext", 32'h80, 1'b1, EXCAUSE_BREAKPOINT, 1'b0, 1'b0, PRIV_U, 1'b1);
    bus.irq_ext = 1'b0;
    wait_csr("irq_ext");
    tick();
    wait_redirect("irq_ext");
    check("irq_ext mstatus", bus.mstatus, 32'h1880);
    tick();
`endif

    check("scoreboard drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
